// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and command payload for the ALU command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic       acc_flag;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // Only add/sub refresh the ALU carry; every other opcode leaves it stale.
  function automatic logic carry_valid(input logic [2:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; head word is read combinationally.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_seq.sv
// ALU command sequencer: queues commands, drives the ALU one at a time, and
// holds each result in a valid/ready response register plus an accumulator.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_opcode,
  input  logic [7:0]             cmd_op1,
  input  logic [7:0]             cmd_op2,
  input  logic                   cmd_acc,
  output logic [2:0]             alu_opcode,
  output logic [7:0]             alu_op1,
  output logic [7:0]             alu_op2,
  input  logic [15:0]            alu_result,
  input  logic                   alu_flagc,
  input  logic                   alu_flagz,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_result,
  output logic                   rsp_flagc,
  output logic                   rsp_flagz,
  output logic [7:0]             acc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [2:0]    alu_opcode_q, alu_opcode_d;
  logic [7:0]    alu_op1_q, alu_op1_d;
  logic [7:0]    alu_op2_q, alu_op2_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic          rsp_flagc_q, rsp_flagc_d;
  logic          rsp_flagz_q, rsp_flagz_d;
  logic [7:0]    acc_q, acc_d;

  cmd_t          cmd_in;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] fifo_count;

  assign cmd_in    = '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2, acc_flag: cmd_acc};
  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .rdata_c (head),
    .count_o (fifo_count)
  );

  // Next-state, issue and capture logic.
  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flagc_d  = rsp_flagc_q;
    rsp_flagz_d  = rsp_flagz_q;
    acc_d        = acc_q;
    issue        = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_count != '0) issue = 1'b1;
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flagz_d  = alu_flagz;
        rsp_flagc_d  = carry_valid(alu_opcode_q) ? alu_flagc : 1'b0;
        acc_d        = alu_result[7:0];
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (fifo_count != '0) issue = 1'b1;
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The accumulator is already updated when a pop happens, so chaining sees the previous result.
    if (issue) begin
      pop          = 1'b1;
      alu_opcode_d = head.opcode;
      alu_op1_d    = head.acc_flag ? acc_q : head.op1;
      alu_op2_d    = head.op2;
      state_d      = EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flagc_q  <= 1'b0;
      rsp_flagz_q  <= 1'b0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flagc_q  <= rsp_flagc_d;
      rsp_flagz_q  <= rsp_flagz_d;
      acc_q        <= acc_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flagc  = rsp_flagc_q;
  assign rsp_flagz  = rsp_flagz_q;
  assign acc        = acc_q;
  assign count      = fifo_count;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU and an in-order response scoreboard.
module tb_alu_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode;
  logic [7:0]    cmd_op1;
  logic [7:0]    cmd_op2;
  logic          cmd_acc;
  logic [2:0]    alu_opcode;
  logic [7:0]    alu_op1;
  logic [7:0]    alu_op2;
  logic [15:0]   alu_result;
  logic          alu_flagc;
  logic          alu_flagz;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_result;
  logic          rsp_flagc;
  logic          rsp_flagz;
  logic [7:0]    acc;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb [$];
  logic [7:0]  macc;

  always #5 clk = ~clk;

  alu_seq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_op1    (cmd_op1),
    .cmd_op2    (cmd_op2),
    .cmd_acc    (cmd_acc),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_flagc  (alu_flagc),
    .alu_flagz  (alu_flagz),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flagc  (rsp_flagc),
    .rsp_flagz  (rsp_flagz),
    .acc        (acc),
    .count      (count)
  );

  // Behavioural ALU returning {carry, zero, result}; non-add/sub ops present a stale carry of 1.
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [8:0]  d;
    logic        c;
    c = 1'b1;
    case (op)
      3'b000: begin r = 16'(a) + 16'(b); c = r[8]; end
      3'b001: begin d = {1'b0, a} - {1'b0, b}; r = 16'(d); c = d[8]; end
      3'b010: r = 16'(a) * 16'(b);
      3'b011: r = {8'h00, a & b};
      3'b100: r = {8'h00, a | b};
      3'b101: r = {8'h00, ~(a & b)};
      3'b110: r = {8'h00, ~(a | b)};
      default: r = {8'h00, a ^ b};
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  always_comb begin
    {alu_flagc, alu_flagz, alu_result} = alu_f(alu_opcode, alu_op1, alu_op2);
  end

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one command; the expected response is queued at the accepting edge.
  task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic accf);
    int n;
    logic [17:0] e;
    logic [7:0]  a_eff;
    n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_acc = accf;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("push_timeout", 18'(n >= 100), 18'(0));
    @(posedge clk);
    a_eff = accf ? macc : a;
    e = alu_f(op, a_eff, b);
    if (!(op == 3'b000 || op == 3'b001)) e[17] = 1'b0;
    sb.push_back(e);
    macc = e[7:0];
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 18'(n >= 200), 18'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_count",     18'(count),      18'(0));
    chk("rst_cmd_ready", 18'(cmd_ready),  18'(1));
    chk("rst_rsp_valid", 18'(rsp_valid),  18'(0));
    chk("rst_rsp",       {rsp_flagc, rsp_flagz, rsp_result}, 18'(0));
    chk("rst_acc",       18'(acc),        18'(0));
    chk("rst_alu",       {alu_opcode, alu_op1, alu_op2}, 19'(0) > 0 ? 18'h3ffff : 18'(0));
  endtask

  // Response monitor: each accepted response is compared in order against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed %h expected no response", {rsp_flagc, rsp_flagz, rsp_result});
      end
      if (sb.size() != 0) chk("rsp_data", {rsp_flagc, rsp_flagz, rsp_result}, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0;
    cmd_acc = 1'b0; rsp_ready = 1'b1; macc = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add with latency checks: push at N, issue at N+1, capture at N+2.
    push_cmd(3'b000, 8'hFF, 8'h01, 1'b0);
    chk("lat_n_count", 18'(count), 18'(1));
    @(posedge clk); #1;
    chk("lat_n1_alu", 18'({alu_opcode, alu_op1, alu_op2}), 18'({3'b000, 8'hFF, 8'h01}));
    chk("lat_n1_valid", 18'(rsp_valid), 18'(0));
    @(posedge clk); #1;
    chk("lat_n2_valid", 18'(rsp_valid), 18'(1));
    chk("lat_n2_rsp", {rsp_flagc, rsp_flagz, rsp_result}, {1'b1, 1'b0, 16'h0100});
    chk("lat_n2_acc", 18'(acc), 18'(8'h00));
    drain();

    // Chain: mul then acc-flagged add.
    push_cmd(3'b010, 8'h10, 8'h10, 1'b0);
    push_cmd(3'b000, 8'h77, 8'h05, 1'b1);
    drain();
    chk("chain_acc", 18'(acc), 18'(8'h05));

    // Stale carry must not leak into a logic op.
    push_cmd(3'b001, 8'h00, 8'h01, 1'b0);
    push_cmd(3'b011, 8'hF0, 8'h0F, 1'b0);
    drain();

    // Backpressure: response held stable and no pop while rsp_ready is low.
    rsp_ready = 1'b0;
    push_cmd(3'b111, 8'hAA, 8'hAA, 1'b0);
    push_cmd(3'b000, 8'h01, 8'h02, 1'b0);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_wait", 18'(n >= 20), 18'(0));
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp_valid, rsp_flagz, rsp_result}, {1'b1, 1'b1, 16'h0000});
      chk("bp_count", 18'(count), 18'(1));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    drain();

    // Fill: five pushes with the consumer stalled.
    rsp_ready = 1'b0;
    push_cmd(3'b000, 8'h03, 8'h04, 1'b0);
    push_cmd(3'b001, 8'h09, 8'h02, 1'b0);
    push_cmd(3'b100, 8'h0F, 8'hF0, 1'b0);
    push_cmd(3'b110, 8'h00, 8'h00, 1'b0);
    chk("fill4_count", 18'(count), 18'(3));
    chk("fill4_ready", 18'(cmd_ready), 18'(1));
    push_cmd(3'b010, 8'h03, 8'h05, 1'b0);
    chk("fill5_count", 18'(count), 18'(4));
    chk("fill5_ready", 18'(cmd_ready), 18'(0));
    cmd_valid = 1'b1; cmd_opcode = 3'b101; cmd_op1 = 8'h12; cmd_op2 = 8'h34; cmd_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("full_no_push", 18'(count), 18'(4));
    rsp_ready = 1'b1;
    drain();
    chk("fill_empty", 18'(count), 18'(0));

    // Reset while in EXEC with three commands still queued.
    rsp_ready = 1'b0;
    push_cmd(3'b000, 8'h10, 8'h20, 1'b0);
    push_cmd(3'b000, 8'h11, 8'h21, 1'b0);
    push_cmd(3'b000, 8'h12, 8'h22, 1'b0);
    push_cmd(3'b000, 8'h13, 8'h23, 1'b0);
    push_cmd(3'b000, 8'h14, 8'h24, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("exec_count", 18'(count), 18'(3));
    rst_n = 1'b0;
    #1;
    sb.delete();
    macc = 8'h00;
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {rsp_valid, 17'(count)}, 18'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
